// File: rtl/mmu_pkg.sv
// Shared MMU types: access/permission vectors and fault-bit layout.
package mmu_pkg;

  // Bit order {X,W,R} for both requested access and granted permissions.
  typedef logic [2:0] perm_t;
  localparam int unsigned PermR = 0;
  localparam int unsigned PermW = 1;
  localparam int unsigned PermX = 2;

  typedef logic [4:0] fault_t;
  localparam int unsigned FaultNoRead  = 0;
  localparam int unsigned FaultWrProt  = 1;
  localparam int unsigned FaultNoExec  = 2;
  localparam int unsigned FaultPrivRel = 3;
  localparam int unsigned FaultBadReq  = 4;

  function automatic logic perm_is_onehot(perm_t v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/perm_check.sv
// Combinational permission check for a single access request.
module perm_check
  import mmu_pkg::*;
(
  input  perm_t  rwx_i,
  input  logic   user_i,
  input  perm_t  u_perm_i,
  input  perm_t  s_perm_i,
  input  logic   bypass_i,
  output logic   allow_o,
  output fault_t fault_o
);

  perm_t act;
  logic  bad_req;

  always_comb begin
    act     = user_i ? u_perm_i : s_perm_i;
    bad_req = !perm_is_onehot(rwx_i);

    fault_o               = '0;
    fault_o[FaultBadReq]  = bad_req;
    // Privilege-related: user was refused something supervisor would have been granted.
    fault_o[FaultPrivRel] = user_i & (|(rwx_i & ~u_perm_i & s_perm_i));
    fault_o[FaultNoExec]  = rwx_i[PermX] & ~act[PermX];
    fault_o[FaultWrProt]  = rwx_i[PermW] & ~act[PermW];
    fault_o[FaultNoRead]  = rwx_i[PermR] & ~act[PermR];
    allow_o               = (|(rwx_i & act)) & ~bad_req;

    if (bypass_i) begin
      allow_o = 1'b1;
      fault_o = '0;
    end
  end

endmodule

// File: rtl/perm_check_pipe.sv
// Round-robin arbitrated, single-stage registered permission check with fault status register.
module perm_check_pipe
  import mmu_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  localparam int unsigned PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_valid,
  output logic [NUM_PORTS-1:0]          req_ready,
  input  logic [3*NUM_PORTS-1:0]        req_rwx,
  input  logic [NUM_PORTS-1:0]          req_user,
  input  logic [ADDR_W*NUM_PORTS-1:0]   req_addr,
  input  logic [3*NUM_PORTS-1:0]        u_perm,
  input  logic [3*NUM_PORTS-1:0]        s_perm,
  input  logic [NUM_PORTS-1:0]          tt_bypass,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [PORT_W-1:0]             rsp_port,
  output logic                          rsp_allow,
  output logic [4:0]                    rsp_fault,
  output logic [ADDR_W-1:0]             rsp_addr,
  output logic                          fsr_valid,
  output logic [4:0]                    fsr_fault,
  output logic [PORT_W-1:0]             fsr_port,
  output logic [ADDR_W-1:0]             fsr_addr,
  output logic                          fsr_overflow,
  input  logic                          fsr_clear
);

  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_allow_q, rsp_allow_d;
  fault_t            rsp_fault_q, rsp_fault_d, fsr_fault_q, fsr_fault_d;
  logic [PORT_W-1:0] rsp_port_q, rsp_port_d, fsr_port_q, fsr_port_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d, fsr_addr_q, fsr_addr_d;
  logic              fsr_valid_q, fsr_valid_d, fsr_ovf_q, fsr_ovf_d;

  logic              stage_free, found, any_grant, rsp_accept;
  logic [PORT_W-1:0] gnt_idx;
  perm_t             sel_rwx, sel_u, sel_s;
  logic              sel_user, sel_bypass, chk_allow;
  logic [ADDR_W-1:0] sel_addr;
  fault_t            chk_fault;

  assign stage_free = ~rsp_valid_q | rsp_ready;
  assign rsp_accept = rsp_valid_q & rsp_ready;

  // Two passes: ports at or above rr_ptr first, then wrap to the low ports.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found && req_valid[j] && (j >= int'(rr_ptr_q))) begin
        found   = 1'b1;
        gnt_idx = PORT_W'(j);
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        gnt_idx = PORT_W'(j);
      end
    end
    any_grant = found & stage_free & ~rst;

    req_ready  = '0;
    sel_rwx    = '0;
    sel_u      = '0;
    sel_s      = '0;
    sel_user   = 1'b0;
    sel_bypass = 1'b0;
    sel_addr   = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (PORT_W'(j) == gnt_idx) begin
        req_ready[j] = any_grant;
        sel_rwx      = req_rwx[3*j +: 3];
        sel_u        = u_perm[3*j +: 3];
        sel_s        = s_perm[3*j +: 3];
        sel_user     = req_user[j];
        sel_bypass   = tt_bypass[j];
        sel_addr     = req_addr[ADDR_W*j +: ADDR_W];
      end
    end
  end

  perm_check u_check (
    .rwx_i    (sel_rwx),
    .user_i   (sel_user),
    .u_perm_i (sel_u),
    .s_perm_i (sel_s),
    .bypass_i (sel_bypass),
    .allow_o  (chk_allow),
    .fault_o  (chk_fault)
  );

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_allow_d = rsp_allow_q;
    rsp_fault_d = rsp_fault_q;
    rsp_port_d  = rsp_port_q;
    rsp_addr_d  = rsp_addr_q;
    if (any_grant) begin
      rr_ptr_d = (32'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + PORT_W'(1);
    end
    if (stage_free) begin
      rsp_valid_d = any_grant;
      if (any_grant) begin
        rsp_allow_d = chk_allow;
        rsp_fault_d = chk_fault;
        rsp_port_d  = gnt_idx;
        rsp_addr_d  = sel_addr;
      end
    end
  end

  // A faulting accept wins over a coincident clear, but starts a fresh record.
  always_comb begin
    fsr_valid_d = fsr_valid_q;
    fsr_ovf_d   = fsr_ovf_q;
    fsr_fault_d = fsr_fault_q;
    fsr_port_d  = fsr_port_q;
    fsr_addr_d  = fsr_addr_q;
    if (fsr_clear) begin
      fsr_valid_d = 1'b0;
      fsr_ovf_d   = 1'b0;
    end
    if (rsp_accept && (rsp_fault_q != '0)) begin
      if (!fsr_valid_q || fsr_clear) begin
        fsr_valid_d = 1'b1;
        fsr_fault_d = rsp_fault_q;
        fsr_port_d  = rsp_port_q;
        fsr_addr_d  = rsp_addr_q;
      end else begin
        fsr_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_allow_q <= 1'b0;
      rsp_fault_q <= '0;
      rsp_port_q  <= '0;
      rsp_addr_q  <= '0;
      fsr_valid_q <= 1'b0;
      fsr_ovf_q   <= 1'b0;
      fsr_fault_q <= '0;
      fsr_port_q  <= '0;
      fsr_addr_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_allow_q <= rsp_allow_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_port_q  <= rsp_port_d;
      rsp_addr_q  <= rsp_addr_d;
      fsr_valid_q <= fsr_valid_d;
      fsr_ovf_q   <= fsr_ovf_d;
      fsr_fault_q <= fsr_fault_d;
      fsr_port_q  <= fsr_port_d;
      fsr_addr_q  <= fsr_addr_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_allow    = rsp_allow_q;
  assign rsp_fault    = rsp_fault_q;
  assign rsp_port     = rsp_port_q;
  assign rsp_addr     = rsp_addr_q;
  assign fsr_valid    = fsr_valid_q;
  assign fsr_overflow = fsr_ovf_q;
  assign fsr_fault    = fsr_fault_q;
  assign fsr_port     = fsr_port_q;
  assign fsr_addr     = fsr_addr_q;

endmodule

// File: tb/tb_perm_check_pipe.sv
// Directed bench for perm_check_pipe with two ports and 32-bit addresses.
module tb_perm_check_pipe;

  localparam int NP = 2;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   req_valid, req_ready, req_user, tt_bypass;
  logic [3*NP-1:0] req_rwx, u_perm, s_perm;
  logic [AW*NP-1:0] req_addr;
  logic            rsp_valid, rsp_ready, rsp_allow, fsr_valid, fsr_overflow, fsr_clear;
  logic [0:0]      rsp_port, fsr_port;
  logic [4:0]      rsp_fault, fsr_fault;
  logic [AW-1:0]   rsp_addr, fsr_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perm_check_pipe #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rwx      (req_rwx),
    .req_user     (req_user),
    .req_addr     (req_addr),
    .u_perm       (u_perm),
    .s_perm       (s_perm),
    .tt_bypass    (tt_bypass),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_port     (rsp_port),
    .rsp_allow    (rsp_allow),
    .rsp_fault    (rsp_fault),
    .rsp_addr     (rsp_addr),
    .fsr_valid    (fsr_valid),
    .fsr_fault    (fsr_fault),
    .fsr_port     (fsr_port),
    .fsr_addr     (fsr_addr),
    .fsr_overflow (fsr_overflow),
    .fsr_clear    (fsr_clear)
  );

  typedef struct {
    int         port;
    logic [2:0] rwx;
    logic       user;
    logic [2:0] up;
    logic [2:0] sp;
    logic       byp;
    logic [31:0] addr;
    logic       exp_allow;
    logic [4:0] exp_fault;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [2:0] rwx, input logic user,
                          input logic [2:0] up, input logic [2:0] sp, input logic byp,
                          input logic [31:0] addr);
    req_valid[p]        = 1'b1;
    req_rwx[3*p +: 3]   = rwx;
    req_user[p]         = user;
    u_perm[3*p +: 3]    = up;
    s_perm[3*p +: 3]    = sp;
    tt_bypass[p]        = byp;
    req_addr[AW*p +: AW] = addr;
  endtask

  task automatic chk_rsp(input string tag, input logic [63:0] port, input logic [63:0] allow,
                         input logic [63:0] fault, input logic [63:0] addr);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_port"}, 64'(rsp_port), port);
    chk({tag, "_allow"}, 64'(rsp_allow), allow);
    chk({tag, "_fault"}, 64'(rsp_fault), fault);
    chk({tag, "_addr"}, 64'(rsp_addr), addr);
  endtask

  initial begin
    //         port rwx    user up      sp      byp addr          allow fault
    tbl[0] = '{0, 3'b001, 1, 3'b001, 3'b000, 0, 32'h0000_0010, 1, 5'b00000};
    tbl[1] = '{0, 3'b010, 1, 3'b001, 3'b010, 0, 32'h0000_1000, 0, 5'b01010};
    tbl[2] = '{1, 3'b100, 0, 3'b000, 3'b100, 0, 32'h0000_2020, 1, 5'b00000};
    tbl[3] = '{0, 3'b100, 0, 3'b111, 3'b011, 0, 32'h0000_3030, 0, 5'b00100};
    tbl[4] = '{0, 3'b000, 1, 3'b111, 3'b111, 0, 32'h0000_4040, 0, 5'b10000};
    tbl[5] = '{0, 3'b011, 1, 3'b001, 3'b000, 0, 32'h0000_5050, 0, 5'b10010};
    tbl[6] = '{1, 3'b001, 1, 3'b000, 3'b001, 0, 32'hDEAD_BEEF, 0, 5'b01001};
    tbl[7] = '{0, 3'b010, 1, 3'b000, 3'b000, 1, 32'h0000_7070, 1, 5'b00000};
    tbl[8] = '{0, 3'b001, 0, 3'b111, 3'b000, 0, 32'h0000_8080, 0, 5'b00001};
    tbl[9] = '{1, 3'b000, 0, 3'b000, 3'b000, 1, 32'hFFFF_0000, 1, 5'b00000};

    rst = 1'b1; req_valid = '0; req_rwx = '0; req_user = '0; req_addr = '0;
    u_perm = '0; s_perm = '0; tt_bypass = '0; rsp_ready = 1'b1; fsr_clear = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_fault", 64'(rsp_fault), 64'd0);
    chk("reset_fsr_valid", 64'(fsr_valid), 64'd0);
    chk("reset_fsr_addr", 64'(fsr_addr), 64'd0);
    chk("reset_ready_idle", 64'(req_ready), 64'd0);

    for (int i = 0; i < 10; i++) begin
      req_valid = '0;
      set_port(tbl[i].port, tbl[i].rwx, tbl[i].user, tbl[i].up, tbl[i].sp, tbl[i].byp,
               tbl[i].addr);
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(1 << tbl[i].port));
      tick();
      req_valid = '0;
      chk_rsp($sformatf("tbl%0d", i), 64'(tbl[i].port), 64'(tbl[i].exp_allow),
              64'(tbl[i].exp_fault), 64'(tbl[i].addr));
      tick();
      chk($sformatf("tbl%0d_drain", i), 64'(rsp_valid), 64'd0);
    end

    fsr_clear = 1'b1;
    tick();
    fsr_clear = 1'b0;
    chk("clr_fsr_valid", 64'(fsr_valid), 64'd0);
    chk("clr_fsr_ovf", 64'(fsr_overflow), 64'd0);

    // First fault loads the FSR, a second one only flags overflow.
    set_port(0, 3'b010, 1, 3'b001, 3'b010, 0, 32'h0000_1000);
    tick(); req_valid = '0; tick();
    chk("fsr1_valid", 64'(fsr_valid), 64'd1);
    chk("fsr1_fault", 64'(fsr_fault), 64'b01010);
    chk("fsr1_addr", 64'(fsr_addr), 64'h1000);
    chk("fsr1_port", 64'(fsr_port), 64'd0);
    chk("fsr1_ovf", 64'(fsr_overflow), 64'd0);
    set_port(0, 3'b001, 1, 3'b000, 3'b000, 0, 32'h0000_2000);
    tick(); req_valid = '0; tick();
    chk("fsr2_ovf", 64'(fsr_overflow), 64'd1);
    chk("fsr2_addr", 64'(fsr_addr), 64'h1000);
    chk("fsr2_fault", 64'(fsr_fault), 64'b01010);

    // Clear coincident with a faulting accept.
    set_port(1, 3'b000, 0, 3'b111, 3'b111, 0, 32'h0000_3000);
    tick(); req_valid = '0;
    fsr_clear = 1'b1;
    tick();
    fsr_clear = 1'b0;
    chk("clrld_fault", 64'(fsr_fault), 64'b10000);
    chk("clrld_valid", 64'(fsr_valid), 64'd1);
    chk("clrld_ovf", 64'(fsr_overflow), 64'd0);
    chk("clrld_port", 64'(fsr_port), 64'd1);
    chk("clrld_addr", 64'(fsr_addr), 64'h3000);

    // Back-pressure: response holds, nothing granted.
    rsp_ready = 1'b0;
    set_port(0, 3'b001, 1, 3'b001, 3'b000, 0, 32'h0000_4444);
    #1;
    chk("stall_first_ready", 64'(req_ready), 64'b01);
    tick();
    set_port(1, 3'b001, 1, 3'b001, 3'b000, 0, 32'h0000_5555);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_ready", k), 64'(req_ready), 64'd0);
      chk_rsp($sformatf("stall%0d", k), 64'd0, 64'd1, 64'd0, 64'h4444);
      tick();
    end

    // Reset with a response in flight; rr_ptr was 1 before it.
    rst = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    tick();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_allow", 64'(rsp_allow), 64'd0);
    chk("rst_rsp_addr", 64'(rsp_addr), 64'd0);
    chk("rst_rsp_port", 64'(rsp_port), 64'd0);
    chk("rst_fsr_valid", 64'(fsr_valid), 64'd0);
    chk("rst_fsr_fault", 64'(fsr_fault), 64'd0);
    chk("rst_fsr_port", 64'(fsr_port), 64'd0);
    chk("rst_fsr_addr", 64'(fsr_addr), 64'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;

    // Both ports valid continuously: grants alternate starting at port 0.
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("alt%0d_ready", k), 64'(req_ready), 64'(1 << (k % 2)));
      tick();
      chk_rsp($sformatf("alt%0d", k), 64'(k % 2), 64'd1, 64'd0,
              (k % 2 == 0) ? 64'h4444 : 64'h5555);
    end
    req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perm_check_pipe.md
PERM_CHECK_PIPE -- requirements
Module: perm_check_pipe

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of request channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, logical address width carried with each request.
REQ-003 SHALL define local PORT_W = max(1, clog2(NUM_PORTS)).
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  NUM_PORTS  per-port request valid.
REQ-007 SHALL have port req_ready  out  NUM_PORTS  per-port grant; request accepted when valid&ready.
REQ-008 SHALL have port req_rwx  in  3*NUM_PORTS  per-port {x,w,r} access type.
REQ-009 SHALL have port req_user  in  NUM_PORTS  per-port user (1) / supervisor (0) mode.
REQ-010 SHALL have port req_addr  in  ADDR_W*NUM_PORTS  per-port logical address.
REQ-011 SHALL have ports u_perm, s_perm  in  3*NUM_PORTS each  per-port {X,W,R} user/supervisor permissions.
REQ-012 SHALL have port tt_bypass  in  NUM_PORTS  per-port transparent-translation hit.
REQ-013 SHALL have ports rsp_valid out 1, rsp_ready in 1  response handshake.
REQ-014 SHALL have ports rsp_port out PORT_W, rsp_allow out 1, rsp_fault out 5, rsp_addr out ADDR_W.
REQ-015 SHALL have ports fsr_valid out 1, fsr_fault out 5, fsr_port out PORT_W, fsr_addr out ADDR_W, fsr_overflow out 1, fsr_clear in 1  fault status register.

Function
REQ-016 Check rules SHALL be: act = user ? u_perm : s_perm; bad_req = (rwx none or >1 bit set); fault = {bad_req, priv_rel, no_exec, wr_prot, no_read}; priv_rel = user & requested bit denied in u_perm but set in s_perm; allow = any requested bit granted & ~bad_req.
REQ-017 tt_bypass=1 SHALL force allow=1, fault=5'b0.
REQ-018 Output stage SHALL be free when rsp_valid=0 or rsp_ready=1; grant only when free.
REQ-019 Arbitration SHALL be round-robin: highest priority at rr_ptr, then ascending with wrap; at most one req_ready bit set per cycle.
REQ-020 req_ready SHALL be combinational from req_valid, rr_ptr and stage-free; no grant when no port valid.
REQ-021 After grant of port g, rr_ptr SHALL become (g+1) mod NUM_PORTS; unchanged when nothing granted.
REQ-022 Latency SHALL be 1: request accepted at edge N appears on rsp_* after edge N (registered), full throughput of one per cycle when rsp_ready=1.
REQ-023 While rsp_valid=1 and rsp_ready=0, all rsp_* SHALL hold stable.
REQ-024 On response accept (rsp_valid&rsp_ready) with rsp_fault!=0: if fsr_valid=0 load fsr_fault/port/addr, set fsr_valid; else set fsr_overflow, fsr contents unchanged.
REQ-025 fsr_clear SHALL clear fsr_valid and fsr_overflow next edge.
REQ-026 fsr_clear coincident with a faulting accept SHALL load the new fault, fsr_valid=1, fsr_overflow=0.
REQ-027 Faults with tt_bypass or allow-with-zero-fault SHALL never touch the FSR.

Reset
REQ-028 rst SHALL set rsp_valid, rsp_allow, rsp_fault, rsp_port, rsp_addr, fsr_* to 0 and rr_ptr to 0.
REQ-029 rst SHALL take priority over all activity; in-flight response discarded, req_ready=0 during rst.

Structure
REQ-030 Fault bit indices, fault_t (5-bit) and perm_t (3-bit {X,W,R}) SHALL live in shared package mmu_pkg.
REQ-031 The check SHALL reuse one instance of existing combinational perm_check on the arbitrated (muxed) request; arbiter and FSR inline.

Verification
REQ-032 Single port 0, user, r, u_perm=001 -> next cycle rsp_valid=1, allow=1, fault=00000, rsp_port=0.
REQ-033 Ports 0,1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one response per cycle.
REQ-034 rsp_ready=0 for 3 cycles with rsp_valid=1 -> rsp_* constant, req_ready all 0.
REQ-035 User w, u_perm=001, s_perm=010, addr 0x1000 -> fault=01010, fsr_valid=1, fsr_addr=0x1000; second fault -> fsr_overflow=1, fsr_addr still 0x1000.
REQ-036 fsr_clear same cycle as faulting accept (rwx=000) -> fsr_fault=10000, fsr_overflow=0.
REQ-037 rst asserted with rsp_valid=1 -> next cycle all outputs 0, subsequent grant starts at port 0.
